// File: rtl/reg_file_ctrl_fsm.sv
// reg_file_ctrl_fsm: fetch/decode/execute/writeback control FSM driving the register file write and address side
module reg_file_ctrl_fsm #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             instr_req,
  output logic [PC_W-1:0]  pc,
  input  logic             instr_valid,
  input  logic [7:0]       instr_rdata,
  output logic [1:0]       Register_Destination,
  output logic             Register_1_operand,
  output logic             Register_2_operand,
  output logic             write_enable,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT} state_t;
  state_t state;
  logic [7:0] ir;
  logic [3:0] opcode;
  logic is_wr, is_ill, is_halt;
  logic [2:0] alu_dec;
  // opcode classification from the latched instruction
  always_comb begin
    opcode  = ir[7:4];
    is_wr   = (opcode >= 4'h1) && (opcode <= 4'h6);
    is_ill  = (opcode >= 4'h7) && (opcode <= 4'hE);
    is_halt = opcode == 4'hF;
    alu_dec = is_wr ? 3'(opcode - 4'h1) : 3'b000;
  end
  // state machine; every output is a register updated on the transition into the cycle it describes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                <= IDLE;
      ir                   <= 8'h00;
      pc                   <= RESET_PC;
      instr_req            <= 1'b0;
      Register_Destination <= 2'b00;
      Register_1_operand   <= 1'b0;
      Register_2_operand   <= 1'b0;
      write_enable         <= 1'b0;
      alu_op               <= 3'b000;
      halted               <= 1'b0;
      illegal              <= 1'b0;
      retired              <= '0;
    end else begin
      write_enable <= 1'b0;
      illegal      <= 1'b0;
      case (state)
        IDLE: if (run) begin
          state     <= FETCH;
          instr_req <= 1'b1;
        end
        FETCH: if (instr_valid) begin
          ir        <= instr_rdata;
          instr_req <= 1'b0;
          pc        <= pc + PC_W'(1);
          state     <= DECODE;
        end
        DECODE: begin
          Register_Destination <= ir[3:2];
          Register_1_operand   <= ir[1];
          Register_2_operand   <= ir[0];
          alu_op               <= alu_dec;
          state                <= EXECUTE;
        end
        EXECUTE: begin
          write_enable <= is_wr;
          illegal      <= is_ill;
          if (!is_halt) retired <= retired + CNT_W'(1);
          state <= WRITEBACK;
        end
        WRITEBACK: if (is_halt) begin
          state  <= HALT;
          halted <= 1'b1;
        end else begin
          state     <= FETCH;
          instr_req <= 1'b1;
        end
        HALT: state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_file_ctrl_fsm.sv
// tb_reg_file_ctrl_fsm: directed checks of fetch/decode/writeback timing, stall, illegal, halt, pc wrap and reset
module tb_reg_file_ctrl_fsm;
  logic clk = 1'b0;
  logic rst_n, run, instr_valid;
  logic [7:0] instr_rdata;
  logic instr_req, write_enable, halted, illegal, rs1, rs2;
  logic [7:0] pc, retired;
  logic [1:0] rd;
  logic [2:0] alu_op;
  logic rst_n2, run2, instr_valid2;
  logic [7:0] instr_rdata2;
  logic instr_req2, write_enable2, halted2, illegal2, rs1_2, rs2_2;
  logic [7:0] pc2, retired2;
  logic [1:0] rd2;
  logic [2:0] alu_op2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_file_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .run(run), .instr_req(instr_req), .pc(pc),
    .instr_valid(instr_valid), .instr_rdata(instr_rdata),
    .Register_Destination(rd), .Register_1_operand(rs1), .Register_2_operand(rs2),
    .write_enable(write_enable), .alu_op(alu_op), .halted(halted),
    .illegal(illegal), .retired(retired)
  );

  reg_file_ctrl_fsm #(.RESET_PC(8'hFF)) dut2 (
    .clk(clk), .rst_n(rst_n2), .run(run2), .instr_req(instr_req2), .pc(pc2),
    .instr_valid(instr_valid2), .instr_rdata(instr_rdata2),
    .Register_Destination(rd2), .Register_1_operand(rs1_2), .Register_2_operand(rs2_2),
    .write_enable(write_enable2), .alu_op(alu_op2), .halted(halted2),
    .illegal(illegal2), .retired(retired2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; instr_valid = 1'b0; instr_rdata = 8'h00;
    rst_n2 = 1'b0; run2 = 1'b0; instr_valid2 = 1'b0; instr_rdata2 = 8'h00;
    tick(); tick();
    chk("rst_pc", pc, 8'h00);
    chk("rst_req", instr_req, 1'b0);
    chk("rst_we", write_enable, 1'b0);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_retired", retired, 8'h00);
    chk("rst_alu", alu_op, 3'b000);
    chk("rst_rd", {rd, rs1, rs2}, 4'h0);
    chk("rst2_pc", pc2, 8'hFF);
    // ADD r2 <- r1 + r1, zero-wait fetch
    rst_n = 1'b1; run = 1'b1;
    tick();
    chk("add_fetch_req", instr_req, 1'b1);
    chk("add_fetch_pc", pc, 8'h00);
    run = 1'b0; instr_valid = 1'b1; instr_rdata = 8'h1B;
    tick();
    instr_valid = 1'b0;
    chk("add_dec_req", instr_req, 1'b0);
    chk("add_dec_pc", pc, 8'h01);
    chk("add_dec_we", write_enable, 1'b0);
    tick();
    chk("add_rd", rd, 2'd2);
    chk("add_rs1", rs1, 1'b1);
    chk("add_rs2", rs2, 1'b1);
    chk("add_alu", alu_op, 3'b000);
    chk("add_exe_we", write_enable, 1'b0);
    tick();
    chk("add_wb_we", write_enable, 1'b1);
    chk("add_wb_retired", retired, 8'd1);
    chk("add_wb_illegal", illegal, 1'b0);
    tick();
    chk("add_after_we", write_enable, 1'b0);
    chk("add_next_req", instr_req, 1'b1);
    // MOV r3 <- r0 after three stalled fetch cycles
    tick();
    chk("stall2_req", instr_req, 1'b1);
    chk("stall2_pc", pc, 8'h01);
    chk("stall2_we", write_enable, 1'b0);
    tick();
    chk("stall3_req", instr_req, 1'b1);
    chk("stall3_pc", pc, 8'h01);
    chk("stall3_we", write_enable, 1'b0);
    tick();
    chk("stall4_req", instr_req, 1'b1);
    chk("stall4_pc", pc, 8'h01);
    instr_valid = 1'b1; instr_rdata = 8'h6C;
    tick();
    instr_valid = 1'b0;
    chk("mov_dec_pc", pc, 8'h02);
    chk("mov_dec_req", instr_req, 1'b0);
    tick();
    chk("mov_rd", rd, 2'd3);
    chk("mov_rs", {rs1, rs2}, 2'b00);
    chk("mov_alu", alu_op, 3'b101);
    chk("mov_exe_we", write_enable, 1'b0);
    tick();
    chk("mov_wb_we", write_enable, 1'b1);
    chk("mov_retired", retired, 8'd2);
    tick();
    chk("mov_after_we", write_enable, 1'b0);
    // illegal opcode 0x9
    instr_valid = 1'b1; instr_rdata = 8'h90;
    tick();
    instr_valid = 1'b0;
    chk("ill_pc", pc, 8'h03);
    tick();
    chk("ill_alu", alu_op, 3'b000);
    chk("ill_exe_illegal", illegal, 1'b0);
    tick();
    chk("ill_wb_illegal", illegal, 1'b1);
    chk("ill_wb_we", write_enable, 1'b0);
    chk("ill_retired", retired, 8'd3);
    tick();
    chk("ill_after", illegal, 1'b0);
    chk("ill_next_req", instr_req, 1'b1);
    // HALT
    instr_valid = 1'b1; instr_rdata = 8'hF0;
    tick();
    instr_valid = 1'b0; run = 1'b1;
    chk("halt_pc", pc, 8'h04);
    tick(); tick();
    chk("halt_wb_we", write_enable, 1'b0);
    chk("halt_wb_illegal", illegal, 1'b0);
    chk("halt_wb_retired", retired, 8'd3);
    chk("halt_wb_halted", halted, 1'b0);
    instr_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick();
      chk("halt_req", instr_req, 1'b0);
      chk("halt_sticky", halted, 1'b1);
    end
    chk("halt_pc_frozen", pc, 8'h04);
    chk("halt_retired", retired, 8'd3);
    instr_valid = 1'b0; run = 1'b0; rst_n = 1'b0;
    tick();
    chk("halt_rst_halted", halted, 1'b0);
    chk("halt_rst_pc", pc, 8'h00);
    chk("halt_rst_retired", retired, 8'd0);
    // reset during the writeback of an ADD
    rst_n = 1'b1; run = 1'b1;
    tick();
    run = 1'b0; instr_valid = 1'b1; instr_rdata = 8'h15;
    tick();
    instr_valid = 1'b0;
    tick(); tick();
    chk("mid_wb_we", write_enable, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_we", write_enable, 1'b0);
    chk("mid_rst_req", instr_req, 1'b0);
    chk("mid_rst_pc", pc, 8'h00);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_post_we", write_enable, 1'b0);
      chk("mid_post_req", instr_req, 1'b0);
    end
    // pc wrap from RESET_PC = 0xFF with a NOP
    rst_n2 = 1'b1; run2 = 1'b1;
    tick();
    chk("wrap_req", instr_req2, 1'b1);
    chk("wrap_pc_before", pc2, 8'hFF);
    run2 = 1'b0; instr_valid2 = 1'b1; instr_rdata2 = 8'h00;
    tick();
    instr_valid2 = 1'b0;
    chk("wrap_pc_after", pc2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wrap_we", write_enable2, 1'b0);
    end
    chk("wrap_retired", retired2, 8'd1);
    chk("wrap_next_req", instr_req2, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
